// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, with start/busy/done handshake
// Defining SERIAL_SUBTRACTOR_ADD_MODE_EN adds a mode input; mode=1 computes a + b + bin instead.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   input  logic             mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             diff_bit,
   output logic             diff_bit_valid
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [CW-1:0]    cnt;
   logic             r, r_nx, x, y, d, last, accept;

   assign x      = a_sr[0];
   assign y      = b_sr[0];
   assign d      = x ^ y ^ r;
   assign last   = (cnt == CW'(WIDTH - 1));
   assign accept = start && (state != SHIFT);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   logic add_r;
   assign r_nx = add_r ? ((x & y) | (r & (x ^ y)))
                       : ((~x & y) | (~(x ^ y) & r));
`else
   assign r_nx = (~x & y) | (~(x ^ y) & r);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last)  state_nx = DONE;
         DONE:    state_nx = start ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         r      <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         add_r  <= 1'b0;
`endif
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         r      <= bin;
         cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         add_r  <= mode;
`endif
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         r      <= r_nx;
         cnt    <= cnt + 1'b1;
         res_sr <= {d, res_sr[WIDTH-1:1]};
         // Result outputs only move on the final bit so they stay stable through SHIFT
         if (last) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= r_nx;
         end
      end
   end

   assign busy           = (state == SHIFT);
   assign done           = (state == DONE);
   assign diff_bit_valid = busy;
   assign diff_bit       = busy & d;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, bin, mode;
   logic [W-1:0] a, b;
   logic         busy, done, bout, diff_bit, diff_bit_valid;
   logic [W-1:0] diff;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .a              (a),
      .b              (b),
      .bin            (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      .mode           (mode),
`endif
      .busy           (busy),
      .done           (done),
      .diff           (diff),
      .bout           (bout),
      .diff_bit       (diff_bit),
      .diff_bit_valid (diff_bit_valid)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mbin, input logic mmode);
      longint unsigned av, bv, cv, r;
      logic [W-1:0]    dv;
      logic            bo;
      av = ma; bv = mb; cv = mbin;
      if (mmode) begin
         r  = av + bv + cv;
         bo = (r >= (64'd1 << W));
      end else begin
         r  = av - bv - cv;
         bo = (av < bv + cv);
      end
      dv = r[W-1:0];
      return {bo, dv};
   endfunction

   task automatic wait_done(input bit keep_start, output int cyc, output int busy_cnt,
                            output logic [W-1:0] bits, output logic stable);
      logic [W-1:0] d0;
      int           nb;
      cyc = 0; busy_cnt = 0; bits = '0; stable = 1'b1; nb = 0;
      d0 = diff;
      for (int k = 1; k <= 3 * W; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (diff_bit_valid) begin
            if (nb < W) bits[nb] = diff_bit;
            nb++;
         end
         if (busy && diff !== d0) stable = 1'b0;
         if (done) begin
            cyc   = k;
            start = 1'b0;
            break;
         end
         if (keep_start) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   // Called at a negedge; returns at the negedge inside the DONE cycle with start low
   task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input logic tmode, input bit keep_start,
                         input logic [W-1:0] exp_d, input logic exp_bo);
      int           cyc, bc;
      logic [W-1:0] bits;
      logic         stable;
      a = ta; b = tb; bin = tbin; mode = tmode; start = 1'b1;
      wait_done(keep_start, cyc, bc, bits, stable);
      chk({name, " done_cycle"}, cyc, W + 1);
      chk({name, " busy_cycles"}, bc, W);
      chk({name, " diff"}, 32'(diff), 32'(exp_d));
      chk({name, " bout"}, 32'(bout), 32'(exp_bo));
      chk({name, " serial_bits"}, 32'(bits), 32'(exp_d));
      chk({name, " diff_stable_in_shift"}, 32'(stable), 1);
   endtask

   initial begin
      logic [W:0]   m;
      logic [W-1:0] ra, rb;
      logic         rbin, rmode, seen;

      tbl[0] = '{a: 8'h50, b: 8'h30, bin: 1'b0, d: 8'h20, bo: 1'b0};
      tbl[1] = '{a: 8'h30, b: 8'h50, bin: 1'b0, d: 8'hE0, bo: 1'b1};
      tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
      tbl[3] = '{a: 8'hFF, b: 8'h01, bin: 1'b1, d: 8'hFD, bo: 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; mode = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset diff", 32'(diff), 0);
      chk("reset bout", 32'(bout), 0);
      chk("reset diff_bit", 32'(diff_bit), 0);
      chk("reset diff_bit_valid", 32'(diff_bit_valid), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, 1'b0,
                tbl[i].d, tbl[i].bo);
         @(negedge clk);
         chk($sformatf("vec%0d idle done", i), 32'(done), 0);
         chk($sformatf("vec%0d held diff", i), 32'(diff), 32'(tbl[i].d));
      end

      // Back-to-back: new start in the DONE cycle skips IDLE
      run_op("b2b first", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFD, 1'b0);
      run_op("b2b second", 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
      @(negedge clk);

      // start held through SHIFT with changing operands must be ignored
      run_op("start_in_shift", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h1E, 1'b0);
      @(negedge clk);

      // Reset during the 4th SHIFT cycle
      a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("midrst busy_before", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", 32'(busy), 0);
      chk("midrst diff", 32'(diff), 0);
      chk("midrst bout", 32'(bout), 0);
      chk("midrst diff_bit_valid", 32'(diff_bit_valid), 0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("midrst no_done_after", 32'(seen), 0);

      for (int i = 0; i < 40; i++) begin
         ra    = W'($urandom);
         rb    = W'($urandom);
         rbin  = 1'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         rmode = 1'($urandom);
`else
         rmode = 1'b0;
`endif
         if (i == 0) begin ra = '0; rb = '1; rbin = 1'b1; end
         if (i == 1) begin ra = '1; rb = '0; rbin = 1'b0; end
         m = model(ra, rb, rbin, rmode);
         run_op($sformatf("rand%0d", i), ra, rb, rbin, rmode, 1'b0, m[W-1:0], m[W]);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      @(negedge clk);
      run_op("add_mode", 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name:
serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock, LSB first.
- Returns the difference and borrow-out through a start/busy/done handshake.
- Inverse operation of the team's combinational parallel adder, traded for area in the tile.
- Sits beside the adder. With the optional mode bit it also performs serial addition, so results can be cross-checked against the parallel adder.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready (state IDLE or DONE)
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, high while in DONE
diff  output  WIDTH  result a - b - bin mod 2^WIDTH; valid when done is high, held until next accepted start
bout  output  1  borrow-out; valid with diff, held likewise
diff_bit  output  1  serial result bit produced this cycle
diff_bit_valid  output  1  high for each of the WIDTH SHIFT cycles

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, diff, bout, diff_bit, diff_bit_valid all 0; internal a/b shift registers and borrow flop cleared.
- Reset mid-operation: same result at the next edge; the partial result is discarded and no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 latches a, b, bin into shift regs, borrow flop=bin, bit counter=0, next state SHIFT.
- SHIFT, each cycle: x=a_sr[0], y=b_sr[0], r=borrow flop.
  - d = x^y^r.
  - r' = (~x & y) | (~(x^y) & r).
  - diff_bit=d, diff_bit_valid=1.
  - d shifts into the result register from the MSB side; a_sr and b_sr shift right.
  - Counter increments. After the WIDTH-th bit, next state DONE.
- DONE: lasts exactly one cycle.
  - done=1; diff=assembled result; bout=final borrow.
  - start=1 here is accepted (back-to-back) and goes directly to SHIFT; otherwise go to IDLE.
- start in SHIFT is ignored. Operands are not re-sampled and no error is flagged.
- Latency: start accepted at edge N -> first diff_bit_valid at cycle N+1 -> done at cycle N+WIDTH+1.
- Throughput: one operation per WIDTH+1 cycles.
- diff and bout change only on entry to DONE or on rst, never mid-SHIFT.
- Width rule: diff is modulo 2^WIDTH. bout=1 iff a < b + bin as unsigned values.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ADD_MODE_EN.
- Defined:
  - Adds input port mode (1 bit), captured on accepted start.
  - mode=1 computes a + b + bin serially: sum bit d = x^y^r, carry r' = (x&y)|(r&(x^y)). diff carries the sum and bout carries carry-out.
  - mode=0 is identical to the undefined build.
- Undefined: no mode port; always subtracts.

Test Plan:
- a=8'h50, b=8'h30, bin=0, start pulse at cycle 0 -> done only at cycle 9, diff=8'h20, bout=0; diff_bit sequence LSB-first 0,0,0,0,0,1,0,0.
- a=8'h30, b=8'h50, bin=0 -> diff=8'hE0, bout=1. a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
- a=8'hFF, b=8'h01, bin=1 -> diff=8'hFD, bout=0. Then start held high in the DONE cycle with a=8'h10, b=8'h01 -> no IDLE cycle; next done 9 cycles later with diff=8'h0F.
- start asserted on every SHIFT cycle with changing a/b -> ignored; result still equals the first operands; busy high exactly 8 cycles.
- rst=1 at the 4th SHIFT cycle -> next cycle busy=0, diff=0, bout=0, state IDLE; no done pulse follows.
- With SERIAL_SUBTRACTOR_ADD_MODE_EN, mode=1, a=8'hFF, b=8'h01, bin=1 -> diff=8'h01, bout=1, matching the parallel adder's Sum/Cout for the same A/B/Cin.
